// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and length-byte helper for the SHA-256 message padder.
package sha256_pkg;

    localparam int         SHA256_BLK_W    = 512;
    localparam int         SHA256_BYTES    = 64;
    localparam int         SHA256_LEN_POS  = 56;
    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        LEN,
        PADB,
        EMIT
    } padder_state_t;

    // Byte i (0 = most significant) of the 64-bit big-endian message bit length.
    function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input int i);
        return bit_len[63 - 8*i -: 8];
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Byte stream -> FIPS 180-4 padded 512-bit blocks; block valid 1 cycle after the 64th byte, 2 after msg_done.
// in_ready is low outside FILL; a block is held stable in EMIT until blk_ready, stalling the byte input.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    input  logic                    msg_done,
    output logic                    blk_valid,
    output logic [SHA256_BLK_W-1:0] blk_data,
    output logic                    blk_first,
    output logic                    blk_last,
    input  logic                    blk_ready,
    output logic                    busy
);

    padder_state_t    state;
    padder_state_t    nxt;
    logic [7:0]       mem [SHA256_BYTES];
    logic [6:0]       idx;
    logic [LEN_W-1:0] count;
    logic             first_pending;

    logic [6:0]       idx_inc;
    logic [63:0]      bit_len;

    assign idx_inc = idx + 7'd1;
    assign bit_len = 64'(count) << 3;
    assign busy    = (state != IDLE);

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < SHA256_BYTES; i++) begin
            blk_data[SHA256_BLK_W-1-8*i -: 8] = mem[6'(i)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            nxt           <= IDLE;
            idx           <= '0;
            count         <= '0;
            first_pending <= 1'b0;
            in_ready      <= 1'b0;
            blk_valid     <= 1'b0;
            blk_first     <= 1'b0;
            blk_last      <= 1'b0;
            for (int i = 0; i < SHA256_BYTES; i++) mem[i] <= '0;
        end else if (start) begin
            state         <= FILL;
            nxt           <= IDLE;
            idx           <= '0;
            count         <= '0;
            first_pending <= 1'b1;
            in_ready      <= 1'b1;
            blk_valid     <= 1'b0;
            blk_first     <= 1'b0;
            blk_last      <= 1'b0;
            for (int i = 0; i < SHA256_BYTES; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: ;
                FILL: begin
                    if (in_valid) begin
                        mem[idx[5:0]] <= in_data;
                        idx           <= idx_inc;
                        count         <= count + LEN_W'(1);
                    end
                    if (msg_done) begin
                        state    <= PAD;
                        in_ready <= 1'b0;
                    end else if (in_valid && idx_inc == 7'd64) begin
                        state     <= EMIT;
                        nxt       <= FILL;
                        in_ready  <= 1'b0;
                        blk_valid <= 1'b1;
                        blk_first <= first_pending;
                        blk_last  <= 1'b0;
                    end
                end
                PAD: begin
                    // Bytes past idx are already zero, so only the marker and length need writing.
                    state     <= EMIT;
                    blk_valid <= 1'b1;
                    blk_first <= first_pending;
                    if (idx <= 7'(SHA256_LEN_POS - 1)) begin
                        mem[idx[5:0]] <= SHA256_PAD_BYTE;
                        for (int i = 0; i < 8; i++) mem[6'(SHA256_LEN_POS + i)] <= len_byte(bit_len, i);
                        nxt      <= IDLE;
                        blk_last <= 1'b1;
                    end else if (idx <= 7'd63) begin
                        mem[idx[5:0]] <= SHA256_PAD_BYTE;
                        nxt           <= LEN;
                        blk_last      <= 1'b0;
                    end else begin
                        nxt      <= PADB;
                        blk_last <= 1'b0;
                    end
                end
                LEN, PADB: begin
                    if (state == PADB) mem[0] <= SHA256_PAD_BYTE;
                    for (int i = 0; i < 8; i++) mem[6'(SHA256_LEN_POS + i)] <= len_byte(bit_len, i);
                    state     <= EMIT;
                    nxt       <= IDLE;
                    blk_valid <= 1'b1;
                    blk_first <= first_pending;
                    blk_last  <= 1'b1;
                end
                EMIT: begin
                    if (blk_ready) begin
                        state         <= nxt;
                        first_pending <= 1'b0;
                        idx           <= '0;
                        in_ready      <= (nxt == FILL);
                        blk_valid     <= 1'b0;
                        blk_first     <= 1'b0;
                        blk_last      <= 1'b0;
                        for (int i = 0; i < SHA256_BYTES; i++) mem[i] <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random messages scored against a byte-queue padding model.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         msg_done;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         blk_ready;
    logic         busy;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .msg_done  (msg_done),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_ready (blk_ready),
        .busy      (busy)
    );

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    blk_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           rdy_mode = 0;
    logic [511:0] last_blk = '0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Padding model: message, 0x80, zeros up to 56 mod 64, 64-bit big-endian bit count.
    function automatic void model_push(input byte_q_t msg);
        byte_q_t      p = msg;
        logic [63:0]  bl = 64'(msg.size()) * 64'd8;
        int           nblk;
        blk_t         b;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data = {b.data[503:0], p[k*64 + j]};
            b.first = (k == 0);
            b.last  = (k == nblk - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Consumer: drives blk_ready 2ns after each edge so main-thread mode changes at +1ns apply the same cycle.
    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       blk_ready = 1'b0;
                1:       blk_ready = 1'b1;
                default: blk_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("blk_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.data);
                    check("blk_first", blk_first, e.first);
                    check("blk_last", blk_last, e.last);
                end
                last_blk = blk_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("in_ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit done);
        wait_rdy();
        in_valid = 1'b1;
        in_data  = b;
        msg_done = done;
        tick();
        in_valid = 1'b0;
        msg_done = 1'b0;
    endtask

    task automatic send_done();
        wait_rdy();
        msg_done = 1'b1;
        tick();
        msg_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) check("idle_timeout", 0, 1);
    endtask

    task automatic run_q(input byte_q_t m, input bit done_with_last, input bit gaps);
        model_push(m);
        pulse_start();
        for (int i = 0; i < m.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            send_byte(m[i], done_with_last && (i == m.size() - 1));
        end
        if (!done_with_last || m.size() == 0) send_done();
        wait_idle();
    endtask

    function automatic byte_q_t rand_msg(input int n);
        byte_q_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    initial begin
        byte_q_t      m;
        byte_q_t      abc;
        logic [511:0] held;
        logic         held_first;
        logic         held_last;
        logic [511:0] abc_exp;
        int           n;
        int           lens[11] = '{0, 1, 55, 56, 63, 64, 65, 119, 120, 127, 128};

        abc_exp  = {32'h61626380, 416'b0, 64'h18};
        abc      = '{8'h61, 8'h62, 8'h63};
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        msg_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_blk_first", blk_first, 0);
        check("rst_blk_last", blk_last, 0);
        check("rst_busy", busy, 0);
        check("rst_blk_data", blk_data, 0);

        // "abc": single block with length 0x18
        rdy_mode = 1;
        run_q(abc, 1, 0);
        check("abc_block", last_blk, abc_exp);

        // Empty message and msg_done -> blk_valid latency
        rdy_mode = 0;
        m = {};
        model_push(m);
        pulse_start();
        wait_rdy();
        msg_done = 1'b1;
        tick();
        msg_done = 1'b0;
        check("lat_pad_vld", blk_valid, 0);
        tick();
        check("lat_emit_vld", blk_valid, 1);
        check("lat_emit_busy", busy, 1);
        rdy_mode = 1;
        wait_idle();
        check("empty_block", last_blk, {8'h80, 504'b0});

        // Length boundaries around byte 55/56 and a full block ending with msg_done
        run_q(rand_msg(55), 1, 0);
        run_q(rand_msg(56), 0, 1);
        run_q(rand_msg(64), 1, 0);
        check("padb_block", last_blk, {8'h80, 440'b0, 64'h200});

        // Consumer stall with in_valid held high: block stable, nothing consumed
        rdy_mode = 0;
        m = rand_msg(69);
        model_push(m);
        pulse_start();
        for (int i = 0; i < 64; i++) send_byte(m[i], 1'b0);
        check("lat_full_vld", blk_valid, 1);
        held       = blk_data;
        held_first = blk_first;
        held_last  = blk_last;
        in_valid   = 1'b1;
        in_data    = 8'hA5;
        for (int c = 0; c < 7; c++) begin
            tick();
            check("stall_data", blk_data, held);
            check("stall_flags", {blk_first, blk_last}, {held_first, held_last});
            check("stall_in_ready", in_ready, 0);
            check("stall_vld", blk_valid, 1);
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        for (int i = 64; i < 69; i++) send_byte(m[i], i == 68);
        wait_idle();

        // Asynchronous reset during EMIT
        rdy_mode = 0;
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        n = 0;
        while (blk_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("arst_pre_vld", blk_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vld", blk_valid, 0);
        check("arst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Abort after 10 bytes, then "abc"
        rdy_mode = 1;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
        run_q(abc, 1, 1);
        check("abort_abc", last_blk, abc_exp);

        // Randomised messages with random gaps and consumer stalls
        rdy_mode = 2;
        for (int r = 0; r < 16; r++) begin
            n = (r < 11) ? lens[r] : int'($urandom_range(0, 200));
            run_q(rand_msg(n), bit'($urandom_range(0, 1)), 1'b1);
        end
        check("final_queue", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
